wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage RISC-V core. It accepts retiring instructions from the memory stage over a valid/ready handshake and aligns and sign- or zero-extends load data returned by the data memory. It drives the register file write port, exposes the same write as a forwarding bus for decode, and counts retired instructions. Variable-latency data-memory reads stall the stage, and through `in_ready_o` the pipeline behind it.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.

- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `in_valid_i` input 1: memory stage presents an instruction.
- `in_ready_o` output 1: stage can accept this cycle.
- `in_rd_i` input 5: destination register.
- `in_rd_wen_i` input 1: instruction writes `rd`.
- `in_wb_sel_i` input 2: result source. 0 = ALU, 1 = load, 2 = PC+4, 3 = treated as ALU.
- `in_alu_i` input 32: ALU result.
- `in_pc_i` input 32: instruction PC.
- `in_funct3_i` input 3: load type.
- `in_addr_lo_i` input 2: load byte offset.
- `dmem_rvalid_i` input 1: load data valid this cycle.
- `dmem_rdata_i` input 32: raw aligned word from data memory.
- `rf_wen_o` output 1: register file write enable.
- `rf_waddr_o` output 5: register file write address.
- `rf_wdata_o` output 32: register file write data.
- `fwd_valid_o` output 1: forwarding bus valid; equals `rf_wen_o`.
- `fwd_rd_o` output 5: forwarding bus register; equals `rf_waddr_o`.
- `fwd_data_o` output 32: forwarding bus data; equals `rf_wdata_o`.
- `pend_valid_o` output 1: a load is held awaiting data (load-use hazard).
- `pend_rd_o` output 5: destination of the pending load.
- `instret_o` output `INSTRET_W`: retired-instruction count.

## Operation
- One holding register captures all `in_*` fields on `in_valid_i && in_ready_o`.
- FSM states:
  - EMPTY: nothing held.
  - HOLD: non-load held.
  - WAIT_MEM: load held.
- Transitions:
  - EMPTY: accept → HOLD, or WAIT_MEM if `wb_sel`==1.
  - HOLD: always commits this cycle; accept → HOLD/WAIT_MEM; otherwise → EMPTY.
  - WAIT_MEM: commits only when `dmem_rvalid_i`=1; then accept → HOLD/WAIT_MEM, otherwise → EMPTY; with no data, stays in WAIT_MEM.
- `commit` = (HOLD) || (WAIT_MEM && `dmem_rvalid_i`).
- `in_ready_o` = EMPTY || `commit`. Combinational; no skid buffer.
- `rf_wen_o` = `commit` && `rd_wen` && `rd`≠0. A write to x0 is never issued but still counts as retired.
- Write data:
  - ALU result: `alu`.
  - PC+4: `pc`+4, modulo 2^32.
  - Load: `dmem_rdata_i` shifted right by 8×`addr_lo`, then per `funct3`:
    - 000: LB, sign-extend bits 7:0.
    - 001: LH, sign-extend bits 15:0; half selected by `addr_lo[1]` only.
    - 100: LBU, zero-extend bits 7:0.
    - 101: LHU, zero-extend bits 15:0.
    - Any other value: full word.
- `rf_waddr_o` / `rf_wdata_o` show the held values even when `rf_wen_o`=0. When EMPTY they are 0.
- `pend_valid_o` = WAIT_MEM && `rd_wen` && `rd`≠0 && !`dmem_rvalid_i`. `pend_rd_o` = held `rd`.
- `instret_o` increments by 1 on every `commit`, wrapping at 2^`INSTRET_W`.
- `dmem_rvalid_i` is ignored in EMPTY and HOLD.

## Timing
- Reset asserted, asynchronously: state = EMPTY, holding register = 0, `instret_o` = 0.
- Outputs during reset: `in_ready_o`=1, `rf_wen_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, all `fwd_*`=0, `pend_valid_o`=0, `pend_rd_o`=0.
- Reset mid-load discards the held instruction: no write, no count. A later `dmem_rvalid_i` is ignored.
- Latency for a non-load: accepted at edge N, written at edge N+1 (`rf_wen_o` high during cycle N→N+1).
- Load: written at the edge that ends the first cycle with `dmem_rvalid_i`=1 while in WAIT_MEM. Minimum latency equals a non-load.
- Back-to-back: one commit per cycle sustained when every load sees `dmem_rvalid_i` in its first held cycle.
- Simultaneous commit and accept: the old instruction commits and the new one is captured at the same edge; no bubble.
- Forwarding outputs are valid in the same cycle as the register write. This covers the register file's old-value-on-same-cycle read.

## Test plan
- Reset with `in_valid_i`=0 → all outputs 0, `in_ready_o`=1, `instret_o`=0.
- ALU op, `rd`=5, `alu`=0x1234 → next cycle `rf_wen_o`=1, `rf_waddr_o`=5, `rf_wdata_o`=0x1234 and `fwd_*` identical; `instret_o`=1. Same with `rd`=0 → `rf_wen_o`=0, `instret_o`=2.
- Load sweep, `dmem_rdata_i`=0x80FF7F81:
  - LB, `addr_lo`=0 → 0xFFFFFF81.
  - LBU, `addr_lo`=1 → 0x0000007F.
  - LH, `addr_lo`=2 → 0xFFFF80FF.
  - LHU, `addr_lo`=0 → 0x00007F81.
  - LW → 0x80FF7F81.
- Load, `rd`=7, `dmem_rvalid_i` low for 3 cycles → `in_ready_o`=0, `pend_valid_o`=1, `pend_rd_o`=7, no write for those 3 cycles. Then raise `dmem_rvalid_i` with a new valid input → write commits and the new instruction is accepted at the same edge.
- JAL writeback, `pc`=0xFFFFFFFC, `wb_sel`=2 → `rf_wdata_o`=0x00000000. With `INSTRET_W`=4, 17 commits → `instret_o`=1.
- Assert `rst_i` mid-cycle during WAIT_MEM → outputs 0 immediately; a following `dmem_rvalid_i` pulse produces no write.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, aligns/extends load data,
// drives the register file write port and forwarding bus, counts retirements.
module wb_stage #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [4:0]           in_rd_i,
  input  logic                 in_rd_wen_i,
  input  logic [1:0]           in_wb_sel_i,
  input  logic [31:0]          in_alu_i,
  input  logic [31:0]          in_pc_i,
  input  logic [2:0]           in_funct3_i,
  input  logic [1:0]           in_addr_lo_i,
  input  logic                 dmem_rvalid_i,
  input  logic [31:0]          dmem_rdata_i,
  output logic                 rf_wen_o,
  output logic [4:0]           rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_rd_o,
  output logic [31:0]          fwd_data_o,
  output logic                 pend_valid_o,
  output logic [4:0]           pend_rd_o,
  output logic [INSTRET_W-1:0] instret_o
);

  typedef enum logic [1:0] {StEmpty, StHold, StWaitMem} state_e;

  localparam logic [1:0] SelLoad = 2'd1;
  localparam logic [1:0] SelPc4  = 2'd2;

  state_e               r_state;
  logic [4:0]           r_rd;
  logic                 r_rd_wen;
  logic [1:0]           r_wb_sel;
  logic [31:0]          r_alu;
  logic [31:0]          r_pc;
  logic [2:0]           r_funct3;
  logic [1:0]           r_addr_lo;
  logic [INSTRET_W-1:0] r_instret;

  logic        w_commit;
  logic        w_accept;
  logic        w_held;
  logic        w_rd_live;
  logic [31:0] w_shifted;
  logic [15:0] w_lh_half;
  logic [31:0] w_load_data;
  logic [31:0] w_result;

  assign w_held    = (r_state != StEmpty);
  assign w_commit  = (r_state == StHold) || ((r_state == StWaitMem) && dmem_rvalid_i);
  assign w_accept  = in_valid_i && in_ready_o;
  assign w_rd_live = r_rd_wen && (r_rd != 5'd0);

  assign in_ready_o = (r_state == StEmpty) || w_commit;

  // Load alignment: byte offset shifts the word down; LH picks its half by addr_lo[1].
  assign w_shifted = dmem_rdata_i >> {r_addr_lo, 3'b000};
  assign w_lh_half = r_addr_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    w_load_data = w_shifted;
    unique case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_lh_half[15]}}, w_lh_half};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_comb begin
    w_result = r_alu;
    unique case (r_wb_sel)
      SelLoad: w_result = w_load_data;
      SelPc4:  w_result = r_pc + 32'd4;
      default: w_result = r_alu;
    endcase
  end

  assign rf_wen_o   = w_commit && w_rd_live;
  assign rf_waddr_o = w_held ? r_rd : 5'd0;
  assign rf_wdata_o = w_held ? w_result : 32'd0;

  assign fwd_valid_o = rf_wen_o;
  assign fwd_rd_o    = rf_waddr_o;
  assign fwd_data_o  = rf_wdata_o;

  assign pend_valid_o = (r_state == StWaitMem) && w_rd_live && !dmem_rvalid_i;
  assign pend_rd_o    = r_rd;

  assign instret_o = r_instret;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StEmpty;
      r_rd      <= 5'd0;
      r_rd_wen  <= 1'b0;
      r_wb_sel  <= 2'd0;
      r_alu     <= 32'd0;
      r_pc      <= 32'd0;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
      r_instret <= '0;
    end else begin
      if (w_commit) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
      if (w_accept) begin
        r_rd      <= in_rd_i;
        r_rd_wen  <= in_rd_wen_i;
        r_wb_sel  <= in_wb_sel_i;
        r_alu     <= in_alu_i;
        r_pc      <= in_pc_i;
        r_funct3  <= in_funct3_i;
        r_addr_lo <= in_addr_lo_i;
      end
      case (r_state)
        StEmpty: begin
          if (w_accept) r_state <= (in_wb_sel_i == SelLoad) ? StWaitMem : StHold;
        end
        StHold: begin
          if (w_accept) r_state <= (in_wb_sel_i == SelLoad) ? StWaitMem : StHold;
          else          r_state <= StEmpty;
        end
        StWaitMem: begin
          if (dmem_rvalid_i) begin
            if (w_accept) r_state <= (in_wb_sel_i == SelLoad) ? StWaitMem : StHold;
            else          r_state <= StEmpty;
          end
        end
        default: r_state <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expectations; INSTRET_W=4 to
// exercise counter wrap.
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_rd_i;
  logic        in_rd_wen_i;
  logic [1:0]  in_wb_sel_i;
  logic [31:0] in_alu_i;
  logic [31:0] in_pc_i;
  logic [2:0]  in_funct3_i;
  logic [1:0]  in_addr_lo_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;
  logic        pend_valid_o;
  logic [4:0]  pend_rd_o;
  logic [3:0]  instret_o;

  int checks = 0;
  int errors = 0;

  wb_stage #(.INSTRET_W(4)) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_rd_i       (in_rd_i),
    .in_rd_wen_i   (in_rd_wen_i),
    .in_wb_sel_i   (in_wb_sel_i),
    .in_alu_i      (in_alu_i),
    .in_pc_i       (in_pc_i),
    .in_funct3_i   (in_funct3_i),
    .in_addr_lo_i  (in_addr_lo_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rf_wen_o      (rf_wen_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .fwd_valid_o   (fwd_valid_o),
    .fwd_rd_o      (fwd_rd_o),
    .fwd_data_o    (fwd_data_o),
    .pend_valid_o  (pend_valid_o),
    .pend_rd_o     (pend_rd_o),
    .instret_o     (instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                       input logic [1:0] lo);
    in_valid_i   = v;
    in_rd_i      = rd;
    in_rd_wen_i  = wen;
    in_wb_sel_i  = sel;
    in_alu_i     = alu;
    in_pc_i      = pc;
    in_funct3_i  = f3;
    in_addr_lo_i = lo;
  endtask

  task automatic check_write(input string tag, input logic wen, input logic [4:0] rd,
                             input logic [31:0] data);
    check_val({tag, ".wen"},   32'(rf_wen_o),    32'(wen));
    check_val({tag, ".waddr"}, 32'(rf_waddr_o),  32'(rd));
    check_val({tag, ".wdata"}, rf_wdata_o,       data);
    check_val({tag, ".fvld"},  32'(fwd_valid_o), 32'(wen));
    check_val({tag, ".frd"},   32'(fwd_rd_o),    32'(rd));
    check_val({tag, ".fdata"}, fwd_data_o,       data);
  endtask

  task automatic check_idle(input string tag);
    check_write(tag, 1'b0, 5'd0, 32'd0);
    check_val({tag, ".ready"}, 32'(in_ready_o),   32'd1);
    check_val({tag, ".pend"},  32'(pend_valid_o), 32'd0);
    check_val({tag, ".pendrd"}, 32'(pend_rd_o),   32'd0);
    check_val({tag, ".instret"}, 32'(instret_o),  32'd0);
  endtask

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ld_lo  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] ld_exp [5] = '{32'hFFFFFF81, 32'h0000007F, 32'hFFFF80FF, 32'h00007F81, 32'h80FF7F81};

  initial begin
    rst_i         = 1'b1;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'd0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);

    @(negedge clk_i);
    check_idle("reset");
    tick();
    rst_i = 1'b0;

    // ALU write to x5, then ALU write to x0 back-to-back
    drive(1'b1, 5'd5, 1'b1, 2'd0, 32'h1234, 32'd0, 3'd0, 2'd0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 2'd0, 32'h55, 32'd0, 3'd0, 2'd0);
    @(negedge clk_i);
    check_write("alu_x5", 1'b1, 5'd5, 32'h1234);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    @(negedge clk_i);
    check_val("x0.wen", 32'(rf_wen_o), 32'd0);
    check_val("x0.instret", 32'(instret_o), 32'd1);
    tick();
    @(negedge clk_i);
    check_val("after_x0.instret", 32'(instret_o), 32'd2);
    check_val("after_x0.waddr", 32'(rf_waddr_o), 32'd0);

    // Load sweep, data valid every cycle so loads stream back-to-back
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h80FF7F81;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd3, 1'b1, 2'd1, 32'd0, 32'd0, ld_f3[i], ld_lo[i]);
      tick();
      @(negedge clk_i);
      check_write($sformatf("load%0d", i), 1'b1, 5'd3, ld_exp[i]);
    end
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    @(negedge clk_i);
    check_val("sweep.instret", 32'(instret_o), 32'd7);

    // Load to x7 stalled three cycles, next instruction waiting at the input
    dmem_rvalid_i = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 2'd1, 32'd0, 32'd0, 3'b010, 2'd0);
    tick();
    drive(1'b1, 5'd9, 1'b1, 2'd0, 32'hABCD, 32'd0, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_val($sformatf("stall%0d.ready", i), 32'(in_ready_o), 32'd0);
      check_val($sformatf("stall%0d.pend", i), 32'(pend_valid_o), 32'd1);
      check_val($sformatf("stall%0d.pendrd", i), 32'(pend_rd_o), 32'd7);
      check_val($sformatf("stall%0d.wen", i), 32'(rf_wen_o), 32'd0);
      tick();
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h11223344;
    @(negedge clk_i);
    check_write("stall_commit", 1'b1, 5'd7, 32'h11223344);
    check_val("stall_commit.ready", 32'(in_ready_o), 32'd1);
    check_val("stall_commit.pend", 32'(pend_valid_o), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    @(negedge clk_i);
    check_write("after_stall", 1'b1, 5'd9, 32'hABCD);
    tick();
    @(negedge clk_i);
    check_val("stall.instret", 32'(instret_o), 32'd9);

    // JAL at top of address space wraps PC+4 to zero
    drive(1'b1, 5'd1, 1'b1, 2'd2, 32'hDEAD, 32'hFFFFFFFC, 3'd0, 2'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    @(negedge clk_i);
    check_write("jal", 1'b1, 5'd1, 32'h0);
    tick();
    @(negedge clk_i);
    check_val("jal.instret", 32'(instret_o), 32'd10);

    // 17 commits from reset wrap a 4-bit counter to 1
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    drive(1'b1, 5'd2, 1'b1, 2'd0, 32'h77, 32'd0, 3'd0, 2'd0);
    for (int i = 0; i < 17; i++) tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    tick();
    @(negedge clk_i);
    check_val("wrap.instret", 32'(instret_o), 32'd1);

    // Reset during WAIT_MEM discards the load
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 2'd1, 32'd0, 32'd0, 3'b010, 2'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 2'd0);
    @(negedge clk_i);
    check_val("midrst.pend_before", 32'(pend_valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_idle("midrst");
    tick();
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFEF00D;
    @(negedge clk_i);
    check_val("midrst.late_wen", 32'(rf_wen_o), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_val("midrst.instret", 32'(instret_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
